// File: rtl/xgs_spi_slave.sv
// SPI mode-0 slave bridging 16-bit command/data frames onto a simple register bus.
// Command word = {addr[14:0], rw}; reads prefetch one word ahead so burst transfers can stream.
module xgs_spi_slave #(
    parameter int CLK_DIV_MIN = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [14:0] reg_addr,
    output logic        reg_wr_en,
    output logic [15:0] reg_wdata,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rdata,
    output logic [7:0]  abort_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_WAIT_CS = 3'd4;

    // The read fetch needs two sclk cycles between an spi_sclk rise and the following fall.
    if (CLK_DIV_MIN < 6) begin : g_div_check
        $error("xgs_spi_slave: CLK_DIV_MIN must be at least 6");
    end

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   settle_sr;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   settled;
    logic                   cs_rise;
    logic                   cs_fall;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic [2:0]  state;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_sr;
    logic [15:0] miso_sr;
    logic        miso_q;
    logic        rd_mode;
    logic        fetch_ph;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign settled = settle_sr[SYNC_STAGES];

    // Edges are suppressed until the synchronizers hold real samples again after reset,
    // so a cs_n that is already low cannot fake a frame start.
    assign cs_rise   = settled &  cs_s   & ~cs_d;
    assign cs_fall   = settled & ~cs_s   &  cs_d;
    assign sclk_rise = settled &  sclk_s & ~sclk_d;
    assign sclk_fall = settled & ~sclk_s &  sclk_d;

    assign spi_miso_oe = (state == ST_DATA) && rd_mode;
    assign spi_miso    = spi_miso_oe & miso_q;

    always_ff @(posedge sclk) begin
        if (srst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
            settle_sr <= '0;
        end else begin
            cs_sync[0]   <= spi_cs_n;
            sclk_sync[0] <= spi_sclk;
            mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]   <= cs_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            settle_sr <= {settle_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_sr  <= '0;
            miso_sr   <= '0;
            miso_q    <= 1'b0;
            rd_mode   <= 1'b0;
            fetch_ph  <= 1'b0;
            reg_addr  <= '0;
            reg_wr_en <= 1'b0;
            reg_wdata <= '0;
            reg_rd_en <= 1'b0;
            abort_cnt <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            // Burst write: the address advances once the strobe cycle has used it.
            if (reg_wr_en) begin
                reg_addr <= reg_addr + 15'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= 4'd0;
                    end
                end

                ST_CMD: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (bit_cnt != 4'd0 && abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                    end else if (sclk_rise) begin
                        shift_sr <= {shift_sr[13:0], mosi_s};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            reg_addr <= shift_sr;
                            rd_mode  <= mosi_s;
                            if (mosi_s) begin
                                reg_rd_en <= 1'b1;
                                fetch_ph  <= 1'b0;
                                state     <= ST_FETCH;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end

                // reg_rd_en is high during the first FETCH cycle; data is captured a cycle later.
                ST_FETCH: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (sclk_rise) begin
                        state <= ST_WAIT_CS;
                    end else if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        miso_sr <= reg_rdata;
                        miso_q  <= 1'b0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (bit_cnt != 4'd0 && abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (!rd_mode) begin
                            shift_sr <= {shift_sr[13:0], mosi_s};
                        end
                        if (bit_cnt == 4'd15) begin
                            if (rd_mode) begin
                                reg_addr  <= reg_addr + 15'd1;
                                reg_rd_en <= 1'b1;
                                fetch_ph  <= 1'b0;
                                state     <= ST_FETCH;
                            end else begin
                                reg_wr_en <= 1'b1;
                                reg_wdata <= {shift_sr, mosi_s};
                            end
                        end
                    end else if (sclk_fall && rd_mode) begin
                        miso_q  <= miso_sr[15];
                        miso_sr <= {miso_sr[14:0], 1'b0};
                    end
                end

                ST_WAIT_CS: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xgs_spi_slave.md
XGS_SPI_SLAVE -- requirements
Module: xgs_spi_slave

Interface
REQ-001 SHALL have parameter CLK_DIV_MIN, default 8, meaning the minimum sclk cycles per spi_sclk period the block supports.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_cs_n, spi_sclk and spi_mosi.
REQ-003 SHALL have a single clock and a synchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 SHALL have port sclk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 SHALL have port srst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port spi_cs_n, input, 1 bit: SPI chip select, active low, asynchronous to sclk.
REQ-007 SHALL have port spi_sclk, input, 1 bit: SPI clock, mode 0, idle low.
REQ-008 SHALL have port spi_mosi, input, 1 bit: master-out data, MSB first.
REQ-009 SHALL have port spi_miso, output, 1 bit: slave-out data.
REQ-010 SHALL have port spi_miso_oe, output, 1 bit: MISO drive enable.
REQ-011 SHALL have port reg_addr, output, 15 bits: register word address.
REQ-012 SHALL have port reg_wr_en, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port reg_wdata, output, 16 bits: write data, valid with reg_wr_en.
REQ-014 SHALL have port reg_rd_en, output, 1 bit: one-cycle read strobe.
REQ-015 SHALL have port reg_rdata, input, 16 bits: read data, valid exactly 1 sclk after reg_rd_en.
REQ-016 SHALL have port abort_cnt, output, 8 bits: saturating count of aborted frames.

Function
REQ-017 SHALL synchronize spi_cs_n, spi_sclk and spi_mosi with SYNC_STAGES flops, then detect spi_sclk rise and fall edges on the synchronized copy.
REQ-018 SHALL sample MOSI on detected spi_sclk rise; SHALL update MISO on detected spi_sclk fall.
REQ-019 SHALL implement states IDLE, CMD, FETCH, DATA, WAIT_CS.
REQ-020 SHALL enter CMD from IDLE when synchronized cs_n falls; the bit counter clears to 0.
REQ-021 SHALL, in CMD, shift 16 bits: bits[15:1] are the word address and bit[0] is R/W (1 = read, 0 = write).
REQ-022 SHALL, after the 16th CMD bit, load reg_addr and go to FETCH if read, or DATA if write.
REQ-023 SHALL, in FETCH, pulse reg_rd_en for 1 cycle, capture reg_rdata into the MISO shift register on the next cycle, then go to DATA; total latency is 2 sclk, less than the time to the next spi_sclk fall.
REQ-024 SHALL, in DATA read, drive spi_miso_oe=1 and present shift-register bit 15 on each fall, starting at the first fall after the 16th CMD rise.
REQ-025 SHALL, in DATA write, shift 16 MOSI bits, then pulse reg_wr_en for 1 cycle with reg_wdata and the current reg_addr.
REQ-026 SHALL, after each complete 16-bit data word with cs_n still low, increment reg_addr by 1 with wrap from 0x7FFF to 0x0000 (burst mode); a read returns to FETCH and a write stays in DATA.
REQ-027 SHALL, on cs_n rising at a 16-bit word boundary in DATA or at any point in WAIT_CS, return to IDLE with no side effects.
REQ-028 SHALL treat cs_n rising mid-word in CMD or DATA as an abort: no reg_wr_en for the partial word, abort_cnt increments (saturating at 0xFF), and the state returns to IDLE.
REQ-029 SHALL, if a spi_sclk rise occurs in FETCH (an under-run, because the master is too fast), enter WAIT_CS, drive spi_miso=0, and count one abort when cs_n rises.
REQ-030 SHALL drive spi_miso_oe=0 and spi_miso=0 whenever the state is not DATA read.
REQ-031 SHALL, when a cs_n rise and an sclk edge are detected in the same cycle, process cs_n and ignore the edge.
REQ-032 SHALL never assert reg_wr_en and reg_rd_en in the same cycle.

Reset
REQ-033 SHALL, on srst=1 at a sclk edge, set state to IDLE, spi_miso=0, spi_miso_oe=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, abort_cnt=0, bit counter 0, and synchronizers to idle (cs_n=1, spi_sclk=0).
REQ-034 SHALL, when srst is asserted mid-frame, issue no write strobe; after release, SHALL ignore the remainder of that frame and wait for a fresh cs_n fall.

Verification
REQ-035 Single write: cmd addr 0x0010 W, data 0xA5C3, spi_sclk = sclk/8 -> one reg_wr_en with reg_addr=0x0010 and reg_wdata=0xA5C3; abort_cnt=0.
REQ-036 Single read: cmd addr 0x0123 R, reg_rdata=0xBEEF -> one reg_rd_en with addr 0x0123; MISO bits read 0xBEEF; spi_miso_oe high only during the data word.
REQ-037 Burst write at 0x7FFF: three words 0x1111, 0x2222, 0x3333 -> writes to 0x7FFF, 0x0000, 0x0001 in order.
REQ-038 Abort: cs_n rises after 9 data bits of a write -> no reg_wr_en and abort_cnt=1; 300 further aborts -> abort_cnt=0xFF.
REQ-039 Reset mid-frame: srst pulses during bit 5 of the data word -> all outputs at reset values, no write; the next full frame completes normally.
